// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace UART: transmitter states, the ASCII
// characters used to build a trace line, record geometry and hex encoding.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam int TRACE_REC_W = 32;
  localparam int LINE_CHARS  = 12;

  // Uppercase hex digit for one nibble, so the terminal shows e.g. "BEEF".
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_ZERO + {4'h0, nib};
    end else begin
      return ASCII_A + {4'h0, nib} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO holding trace records between capture and the UART.
// A push while full is still accepted when a pop happens on the same edge,
// because the pop frees the slot the push needs.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/cpu_trace_uart.sv
// Watches the simple_cpu debug outputs, captures {pc, instr, acc} whenever
// the PC changes, queues the records and prints each one as a 12-character
// hex line ("PP IIII AA\r\n") over an 8N1 UART. Never drives the CPU.
module cpu_trace_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        trace_en,
  input  logic [7:0]  debug_pc_in,
  input  logic [15:0] debug_instruction_in,
  input  logic [7:0]  debug_acc_in,
  input  logic        clear_stats,
  output logic        uart_tx,
  output logic        trace_busy,
  output logic        trace_overflow,
  output logic [7:0]  dropped_count
);

  import cpu_trace_pkg::*;

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       CHAR_LAST = 4'(LINE_CHARS - 1);

  tx_state_t              state;
  tx_state_t              state_next;
  logic [CNT_W-1:0]       clk_cnt;
  logic [CNT_W-1:0]       clk_cnt_next;
  logic [2:0]             bit_idx;
  logic [2:0]             bit_idx_next;
  logic [3:0]             char_idx;
  logic [3:0]             char_idx_next;
  logic [TRACE_REC_W-1:0] rec;
  logic [TRACE_REC_W-1:0] rec_next;

  logic [7:0]             prev_pc;
  logic                   first_flag;
  logic                   capture;
  logic                   drop;
  logic                   bit_done;
  logic                   tx_bit;
  logic [7:0]             cur_char;

  logic [TRACE_REC_W-1:0] fifo_din;
  logic [TRACE_REC_W-1:0] fifo_dout;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign capture    = trace_en && ((debug_pc_in != prev_pc) || first_flag);
  assign drop       = capture && fifo_full && !fifo_pop;
  assign fifo_din   = {debug_pc_in, debug_instruction_in, debug_acc_in};
  assign bit_done   = (clk_cnt == BIT_LAST);
  assign trace_busy = (state != TX_IDLE) || !fifo_empty;

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50mhz),
    .rst   (rst),
    .push  (capture),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Remember the last PC seen and whether anything has been captured since reset.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      prev_pc    <= 8'h00;
      first_flag <= 1'b1;
    end else begin
      prev_pc <= debug_pc_in;
      if (capture) begin
        first_flag <= 1'b0;
      end
    end
  end

  // Drop statistics; a clear on the same edge as a drop leaves both at zero.
  always_ff @(posedge clk_50mhz) begin
    if (rst || clear_stats) begin
      trace_overflow <= 1'b0;
      dropped_count  <= 8'h00;
    end else if (drop) begin
      trace_overflow <= 1'b1;
      if (dropped_count != 8'hFF) begin
        dropped_count <= dropped_count + 8'd1;
      end
    end
  end

  // Pick the character of the line currently being sent from the held record.
  always_comb begin
    cur_char = ASCII_SPACE;
    case (char_idx)
      4'd0:    cur_char = nibble_to_ascii(rec[31:28]);
      4'd1:    cur_char = nibble_to_ascii(rec[27:24]);
      4'd2:    cur_char = ASCII_SPACE;
      4'd3:    cur_char = nibble_to_ascii(rec[23:20]);
      4'd4:    cur_char = nibble_to_ascii(rec[19:16]);
      4'd5:    cur_char = nibble_to_ascii(rec[15:12]);
      4'd6:    cur_char = nibble_to_ascii(rec[11:8]);
      4'd7:    cur_char = ASCII_SPACE;
      4'd8:    cur_char = nibble_to_ascii(rec[7:4]);
      4'd9:    cur_char = nibble_to_ascii(rec[3:0]);
      4'd10:   cur_char = ASCII_CR;
      4'd11:   cur_char = ASCII_LF;
      default: cur_char = ASCII_SPACE;
    endcase
  end

  // Transmitter state register; reset abandons any frame in progress.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state    <= TX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= 3'd0;
      char_idx <= 4'd0;
      rec      <= '0;
    end else begin
      state    <= state_next;
      clk_cnt  <= clk_cnt_next;
      bit_idx  <= bit_idx_next;
      char_idx <= char_idx_next;
      rec      <= rec_next;
    end
  end

  // Frame sequencing: start bit, 8 data bits LSB first, stop bit, twelve characters per record.
  always_comb begin
    state_next    = state;
    clk_cnt_next  = clk_cnt;
    bit_idx_next  = bit_idx;
    char_idx_next = char_idx;
    rec_next      = rec;
    fifo_pop      = 1'b0;
    tx_bit        = 1'b1;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          rec_next      = fifo_dout;
          char_idx_next = 4'd0;
          clk_cnt_next  = '0;
          state_next    = TX_START;
        end
      end
      TX_START: begin
        tx_bit = 1'b0;
        if (bit_done) begin
          clk_cnt_next = '0;
          bit_idx_next = 3'd0;
          state_next   = TX_DATA;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        tx_bit = cur_char[bit_idx];
        if (bit_done) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = TX_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        tx_bit = 1'b1;
        if (bit_done) begin
          clk_cnt_next = '0;
          if (char_idx < CHAR_LAST) begin
            char_idx_next = char_idx + 4'd1;
            state_next    = TX_START;
          end else begin
            state_next = TX_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

  // Register the serial line so it never glitches; it lags the state by one cycle.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      uart_tx <= 1'b1;
    end else begin
      uart_tx <= tx_bit;
    end
  end

endmodule

// File: tb/tb_cpu_trace_uart.sv
// Self-checking bench for cpu_trace_uart: a transaction-level model (record
// queue plus a busy timer and formatted text line) predicts every output each
// cycle, and a UART receiver decodes the serial line for literal text checks.
module tb_cpu_trace_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LINE_CYCLES = 120 * CPB;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic        trace_en = 1'b0;
  logic [7:0]  debug_pc_in = 8'h00;
  logic [15:0] debug_instruction_in = 16'h0000;
  logic [7:0]  debug_acc_in = 8'h00;
  logic        clear_stats = 1'b0;
  logic        uart_tx;
  logic        trace_busy;
  logic        trace_overflow;
  logic [7:0]  dropped_count;

  int total = 0;
  int bad = 0;

  cpu_trace_uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_50mhz            (clk_50mhz),
    .rst                  (rst),
    .trace_en             (trace_en),
    .debug_pc_in          (debug_pc_in),
    .debug_instruction_in (debug_instruction_in),
    .debug_acc_in         (debug_acc_in),
    .clear_stats          (clear_stats),
    .uart_tx              (uart_tx),
    .trace_busy           (trace_busy),
    .trace_overflow       (trace_overflow),
    .dropped_count        (dropped_count)
  );

  // Free-running clock.
  always #5 clk_50mhz = ~clk_50mhz;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string vis(input string s);
    string r = "";
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (c < 8'h20) r = {r, $sformatf("<%02h>", c)};
      else r = {r, $sformatf("%c", c)};
    end
    return r;
  endfunction

  task automatic checkText(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got \"%s\" expected \"%s\" at %0t", name, vis(act), vis(exp), $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic string fmt_line(input logic [31:0] r);
    string s;
    s = $sformatf("%02h %04h %02h", r[31:24], r[23:8], r[7:0]);
    s = s.toupper();
    return {s, "\r\n"};
  endfunction

  // Serial level at a given cycle offset into a line: 10 bit-times per char.
  function automatic logic line_bit(input string line, input int pos);
    int ch;
    int b;
    logic [7:0] c;
    ch = pos / (10 * CPB);
    b  = (pos % (10 * CPB)) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    c = line.getc(ch);
    return c[b-1];
  endfunction

  logic [31:0] m_q[$];
  int          m_busy = 0;
  int          m_pos = 0;
  string       m_line = "";
  logic [7:0]  m_prev = 8'h00;
  bit          m_first = 1'b1;
  int          m_drops = 0;
  bit          m_ovf = 1'b0;
  bit          m_tx = 1'b1;
  bit          m_pop, m_cap, m_drop;
  bit          chk_en = 1'b0;

  // Model update on each clock edge using the inputs the DUT sees.
  always @(posedge clk_50mhz) begin
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_pos = 0; m_line = "";
      m_prev = 8'h00; m_first = 1'b1;
      m_drops = 0; m_ovf = 1'b0; m_tx = 1'b1;
      chk_en = 1'b1;
    end else begin
      m_tx  = (m_busy > 0) ? line_bit(m_line, m_pos) : 1'b1;
      m_pop = (m_busy == 0) && (m_q.size() > 0);
      m_cap = trace_en && ((debug_pc_in != m_prev) || m_first);
      if (m_busy > 0) begin
        m_busy--;
        m_pos++;
      end
      if (m_pop) begin
        m_line = fmt_line(m_q.pop_front());
        m_busy = LINE_CYCLES;
        m_pos  = 0;
      end
      m_drop = 1'b0;
      if (m_cap) begin
        if (m_q.size() < DEPTH) m_q.push_back({debug_pc_in, debug_instruction_in, debug_acc_in});
        else m_drop = 1'b1;
        m_first = 1'b0;
      end
      if (clear_stats) begin
        m_drops = 0;
        m_ovf   = 1'b0;
      end else if (m_drop) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      m_prev = debug_pc_in;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk_50mhz) begin
    if (chk_en) begin
      checkOutput("cyc_uart_tx", {31'd0, uart_tx}, {31'd0, m_tx});
      checkOutput("cyc_trace_busy", {31'd0, trace_busy}, {31'd0, ((m_busy > 0) || (m_q.size() > 0))});
      checkOutput("cyc_overflow", {31'd0, trace_overflow}, {31'd0, m_ovf});
      checkOutput("cyc_dropped", {24'd0, dropped_count}, 32'(m_drops));
    end
  end

  // ---------------- UART receiver ----------------
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  // Decode 8N1 characters by sampling mid-bit; reset abandons a partial character.
  always @(negedge clk_50mhz) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB) == (CPB / 2)) begin
        if ((rx_cnt / CPB) >= 1 && (rx_cnt / CPB) <= 8) rx_byte[(rx_cnt / CPB) - 1] = uart_tx;
        if ((rx_cnt / CPB) == 9) begin
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  function automatic string rx_string();
    string r = "";
    while (rx_q.size() > 0) r = {r, $sformatf("%c", rx_q.pop_front())};
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] pc, input logic [15:0] instr, input logic [7:0] acc);
    trace_en = en;
    debug_pc_in = pc;
    debug_instruction_in = instr;
    debug_acc_in = acc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (trace_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle_timeout", {31'd0, trace_busy}, 32'd0);
    repeat (4) tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string s;
    logic [7:0] pc;

    checkText("model_fmt_letters", fmt_line(32'hAFBEEFC0), "AF BEEF C0\r\n");
    checkText("model_fmt_digits", fmt_line(32'h00123456), "00 1234 56\r\n");

    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, trace_busy}, 32'd0);
    checkOutput("reset_overflow", {31'd0, trace_overflow}, 32'd0);
    checkOutput("reset_dropped", {24'd0, dropped_count}, 32'd0);

    // Test 1: single record, latency and line length.
    $display("[TB] test 1: single record");
    rx_q.delete();
    applyStimulus(1'b1, 8'h00, 16'h1234, 8'h56);
    tick();
    checkOutput("t1_tx_after_E", {31'd0, uart_tx}, 32'd1);
    tick();
    checkOutput("t1_tx_after_E1", {31'd0, uart_tx}, 32'd1);
    tick();
    checkOutput("t1_tx_after_E2", {31'd0, uart_tx}, 32'd0);
    repeat (LINE_CYCLES - 2) tick();
    checkOutput("t1_busy_at_E480", {31'd0, trace_busy}, 32'd1);
    tick();
    checkOutput("t1_busy_at_E481", {31'd0, trace_busy}, 32'd0);
    repeat (4) tick();
    checkText("t1_line", rx_string(), "00 1234 56\r\n");

    // Test 2: uppercase hex letters.
    $display("[TB] test 2: hex letters");
    applyStimulus(1'b1, 8'hAF, 16'hBEEF, 8'hC0);
    tick();
    wait_idle(1000);
    checkText("t2_line", rx_string(), "AF BEEF C0\r\n");

    // Test 3: overflow with pc changing every cycle.
    $display("[TB] test 3: overflow");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 8'(i), 16'($urandom), 8'($urandom));
      tick();
    end
    checkOutput("t3_dropped", {24'd0, dropped_count}, 32'd5);
    checkOutput("t3_overflow", {31'd0, trace_overflow}, 32'd1);
    wait_idle(4000);
    s = rx_string();
    checkOutput("t3_rx_len", 32'(s.len()), 32'd60);
    for (int i = 0; i < 5; i++) begin
      checkText($sformatf("t3_line%0d_pc", i), s.substr(i * 12, i * 12 + 1), $sformatf("%02h", i + 1));
    end
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checkOutput("t3_clr_dropped", {24'd0, dropped_count}, 32'd0);
    checkOutput("t3_clr_overflow", {31'd0, trace_overflow}, 32'd0);

    // Test 4: trace_en gating.
    $display("[TB] test 4: enable gating");
    applyStimulus(1'b0, 8'h10, 16'h0000, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h11, 16'h0000, 8'h00);
    tick();
    applyStimulus(1'b1, 8'h11, 16'h0000, 8'h00);
    repeat (5) tick();
    checkOutput("t4_no_capture", {31'd0, trace_busy}, 32'd0);
    applyStimulus(1'b1, 8'h12, 16'hA5A5, 8'h3C);
    tick();
    wait_idle(1000);
    s = rx_string();
    checkText("t4_line", s, "12 A5A5 3C\r\n");

    // Test 6: saturation, then clear coinciding with a drop.
    $display("[TB] test 6: saturation");
    for (int i = 0; i < 320; i++) begin
      applyStimulus(1'b1, (i % 2 == 1) ? 8'h41 : 8'h40, 16'($urandom), 8'($urandom));
      tick();
    end
    checkOutput("t6_saturated", {24'd0, dropped_count}, 32'd255);
    checkOutput("t6_overflow", {31'd0, trace_overflow}, 32'd1);
    applyStimulus(1'b1, 8'h40, 16'h0000, 8'h00);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checkOutput("t6_clr_wins_count", {24'd0, dropped_count}, 32'd0);
    checkOutput("t6_clr_wins_flag", {31'd0, trace_overflow}, 32'd0);
    applyStimulus(1'b1, 8'h41, 16'h0000, 8'h00);
    tick();
    checkOutput("t6_drop_after_clr", {24'd0, dropped_count}, 32'd1);
    wait_idle(4000);
    s = rx_string();
    checkOutput("t6_rx_len", 32'(s.len()), 32'd60);

    // Test 5: reset in the middle of char 5's data bits.
    $display("[TB] test 5: reset mid-frame");
    applyStimulus(1'b1, 8'h33, 16'h7E57, 8'h99);
    tick();
    repeat (211) tick();
    rst = 1'b1;
    tick();
    checkOutput("t5_tx_high", {31'd0, uart_tx}, 32'd1);
    checkOutput("t5_busy", {31'd0, trace_busy}, 32'd0);
    checkOutput("t5_dropped", {24'd0, dropped_count}, 32'd0);
    checkOutput("t5_overflow", {31'd0, trace_overflow}, 32'd0);
    rst = 1'b0;
    rx_q.delete();
    tick();
    checkOutput("t5_first_capture", {31'd0, trace_busy}, 32'd1);
    wait_idle(1000);
    checkText("t5_line", rx_string(), "33 7E57 99\r\n");

    // Randomised traffic checked by the cycle model.
    $display("[TB] random phase");
    pc = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) pc = 8'($urandom_range(0, 7));
      clear_stats = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 999) == 0);
      applyStimulus($urandom_range(0, 9) != 0, pc, 16'($urandom), 8'($urandom));
      tick();
    end
    rst = 1'b0;
    clear_stats = 1'b0;
    wait_idle(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
